// File: rtl/seq_alu.sv
// Multi-cycle integer execution unit: ADD/SUB/AND/ADDI in one cycle, SLL/SRL bit-serial, MUL shift-add.
// Ports: clk/rst; in_valid/in_ready + op/a/b/imm request side; out_valid/out_ready + result/carry/ovf/zero/illegal.
// Latency: 1 for single-cycle ops and zero shifts, k+1 for shifts by k (k clamped to W), W+1 for MUL.
module seq_alu #(
  parameter int W     = 16,
  parameter int IMM_W = 8,
  parameter int SH_W  = $clog2(W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  localparam logic [SH_W-1:0] W_CNT = SH_W'(W);
  localparam logic [SH_W-1:0] ONE   = SH_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  // acc holds the shift operand (low W bits) or the 2W-bit MUL partial product.
  logic [2*W-1:0]    acc_q, acc_d;
  logic [2*W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]      mplier_q, mplier_d;
  logic [W-1:0]      result_q, result_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  // Single-cycle arithmetic, evaluated straight from the request inputs.
  logic [W-1:0]      imm_ext;
  logic [W-1:0]      addend;
  logic [W:0]        add_sum;
  logic              add_ovf;
  logic [W-1:0]      sub_dif;
  logic              sub_ovf;
  logic [SH_W-1:0]   sh_raw, sh_k;

  assign imm_ext = W'($signed(imm));
  assign addend  = (op == OP_ADDI) ? imm_ext : b;
  assign add_sum = {1'b0, a} + {1'b0, addend};
  assign add_ovf = (a[W-1] == addend[W-1]) && (add_sum[W-1] != a[W-1]);
  assign sub_dif = a + ~b + W'(1);
  assign sub_ovf = (a[W-1] != b[W-1]) && (sub_dif[W-1] != a[W-1]);
  assign sh_raw  = b[SH_W-1:0];
  assign sh_k    = (sh_raw > W_CNT) ? W_CNT : sh_raw;

  // Per-cycle step values for the iterative ops.
  logic [2*W-1:0]    acc_nxt;
  logic [W-1:0]      sh_nxt;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign sh_nxt  = (op_q == OP_SRL) ? (acc_q[W-1:0] >> 1) : (acc_q[W-1:0] << 1);

  // Result and flags are written only when entering DONE, so BUSY leaves
  // the previous result visible.
  logic              fin;
  logic [W-1:0]      fin_res;
  logic              fin_c, fin_v, fin_ill;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    fin       = 1'b0;
    fin_res   = '0;
    fin_c     = 1'b0;
    fin_v     = 1'b0;
    fin_ill   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          case (op)
            OP_ADD, OP_ADDI: begin
              fin = 1'b1; fin_res = add_sum[W-1:0]; fin_c = add_sum[W]; fin_v = add_ovf;
            end
            OP_SUB: begin
              fin = 1'b1; fin_res = sub_dif; fin_c = (a < b); fin_v = sub_ovf;
            end
            OP_AND: begin
              fin = 1'b1; fin_res = a & b;
            end
            OP_SLL, OP_SRL: begin
              if (sh_k == '0) begin
                fin = 1'b1; fin_res = a;
              end else begin
                acc_d   = {{W{1'b0}}, a};
                cnt_d   = sh_k;
                state_d = BUSY;
              end
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = {{W{1'b0}}, a};
              mplier_d = b;
              cnt_d    = W_CNT;
              state_d  = BUSY;
            end
            default: begin
              fin = 1'b1; fin_ill = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - ONE;
        if (op_q == OP_MUL) begin
          acc_d    = acc_nxt;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          acc_d = {{W{1'b0}}, sh_nxt};
        end
        // The final step is folded into the cycle that leaves BUSY.
        if (cnt_q == ONE) begin
          fin = 1'b1;
          if (op_q == OP_MUL) begin
            fin_res = acc_nxt[W-1:0];
            fin_v   = |acc_nxt[2*W-1:W];
          end else begin
            fin_res = sh_nxt;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d   = DONE;
      result_d  = fin_res;
      carry_d   = fin_c;
      ovf_d     = fin_v;
      zero_d    = (fin_res == '0);
      illegal_d = fin_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu at W=16, IMM_W=8.
// Expected results are pushed to a scoreboard queue when an op is issued and popped when out_valid appears.
// Fixed vectors carry hand-derived expectations; the random mix uses a behavioural reference model.
module tb_seq_alu;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, ADDI = 3'b011;
  localparam logic [2:0] SLL = 3'b100, SRL = 3'b101, MUL = 3'b110, RES = 3'b111;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        ill;
  } flags_t;

  typedef struct packed {
    flags_t f;
    int     lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry;
  logic        ovf;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  seq_alu #(.W(16), .IMM_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .ovf(ovf), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic v,
                              input logic z, input logic il, input int lat);
    exp_t e;
    e.f   = '{res: r, c: c, v: v, z: z, ill: il};
    e.lat = lat;
    return e;
  endfunction

  // Behavioural reference: wide integer arithmetic, independent of the RTL structure.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] x,
                                 input logic [15:0] y, input logic [7:0] im);
    exp_t        e;
    logic [16:0] s;
    logic [15:0] ye;
    logic [31:0] p;
    int          sv;
    int          k;
    e = mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    ye = {{8{im[7]}}, im};
    k  = int'(y[4:0]);
    case (o)
      ADD, ADDI: begin
        if (o == ADDI) y = ye;
        s = {1'b0, x} + {1'b0, y};
        e.f.res = s[15:0];
        e.f.c   = s[16];
        sv = int'($signed(x)) + int'($signed(y));
        e.f.v = (sv > 32767) || (sv < -32768);
      end
      SUB: begin
        e.f.res = x - y;
        e.f.c   = (x < y);
        sv = int'($signed(x)) - int'($signed(y));
        e.f.v = (sv > 32767) || (sv < -32768);
      end
      AND_: e.f.res = x & y;
      SLL, SRL: begin
        if (k >= 16) e.f.res = 16'h0;
        else if (o == SLL) e.f.res = x << k;
        else e.f.res = x >> k;
        e.lat = (k == 0) ? 1 : ((k >= 16) ? 17 : k + 1);
      end
      MUL: begin
        p = {16'h0, x} * {16'h0, y};
        e.f.res = p[15:0];
        e.f.v   = (p[31:16] != 16'h0);
        e.lat   = 17;
      end
      default: e.f.ill = 1'b1;
    endcase
    e.f.z = (e.f.res == 16'h0);
    return e;
  endfunction

  // Driver: issues one op, scrambles inputs after accept, waits (bounded) for
  // out_valid, captures outputs, then completes the output handshake.
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [7:0] im, output flags_t ob, output int lat);
    int w;
    op = o; a = x; b = y; imm = im; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = 16'($urandom); b = 16'($urandom); imm = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    ob = '{res: result, c: carry, v: ovf, z: zero, ill: illegal};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 16'h0; b = 16'h0; imm = 8'h0;
    #3;
    checks++;
    if ({in_ready, out_valid, result, carry, ovf, zero, illegal} !== {1'b1, 1'b0, 16'h0, 4'b0000}) begin
      errors++;
      $display("FAIL reset: rdy/vld/res/cvzi got %b/%b/%h/%b%b%b%b need 1/0/0000/0000",
               in_ready, out_valid, result, carry, ovf, zero, illegal);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_arith;
    logic [2:0] o; logic [15:0] x, y; logic [7:0] im; exp_t e; flags_t ob; int lat;
    for (int i = 0; i < 8; i++) begin
      im = 8'h00;
      case (i)
        0: begin o = ADD;  x = 16'hFFFF; y = 16'h0001; e = mk(16'h0000, 1, 0, 1, 0, 1); end
        1: begin o = ADD;  x = 16'h7FFF; y = 16'h0001; e = mk(16'h8000, 0, 1, 0, 0, 1); end
        2: begin o = SUB;  x = 16'h0003; y = 16'h0005; e = mk(16'hFFFE, 1, 0, 0, 0, 1); end
        3: begin o = SUB;  x = 16'h8000; y = 16'h0001; e = mk(16'h7FFF, 0, 1, 0, 0, 1); end
        4: begin o = ADDI; x = 16'h0010; y = 16'h1234; im = 8'hF0; e = mk(16'h0000, 1, 0, 1, 0, 1); end
        5: begin o = ADDI; x = 16'h7FF0; y = 16'h0000; im = 8'h7F; e = mk(16'h806F, 0, 1, 0, 0, 1); end
        6: begin o = AND_; x = 16'hF0F0; y = 16'h0FF0; e = mk(16'h00F0, 0, 0, 0, 0, 1); end
        default: begin o = RES; x = 16'hFFFF; y = 16'hFFFF; e = mk(16'h0000, 0, 0, 1, 1, 1); end
      endcase
      exp_q.push_back(e);
      run_op(o, x, y, im, ob, lat);
      e = exp_q.pop_front();
      checks++;
      if (ob !== e.f) begin
        errors++;
        $display("FAIL arith[%0d] res/cvzi got %h need %h", i, ob, e.f);
      end
      checks++;
      if (lat != e.lat) begin
        errors++;
        $display("FAIL arith_lat[%0d] got %0d need %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_shift;
    logic [2:0] o; logic [15:0] x, y; exp_t e; flags_t ob; int lat;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin o = SLL; x = 16'h0001; y = 16'd4;  e = mk(16'h0010, 0, 0, 0, 0, 5);  end
        1: begin o = SRL; x = 16'h8000; y = 16'd15; e = mk(16'h0001, 0, 0, 0, 0, 16); end
        2: begin o = SLL; x = 16'h0001; y = 16'd20; e = mk(16'h0000, 0, 0, 1, 0, 17); end
        3: begin o = SLL; x = 16'h1234; y = 16'd0;  e = mk(16'h1234, 0, 0, 0, 0, 1);  end
        4: begin o = SRL; x = 16'hF00F; y = 16'h0FE4; e = mk(16'h0F00, 0, 0, 0, 0, 5); end
        default: begin o = SRL; x = 16'hFFFF; y = 16'd16; e = mk(16'h0000, 0, 0, 1, 0, 17); end
      endcase
      exp_q.push_back(e);
      run_op(o, x, y, 8'h00, ob, lat);
      e = exp_q.pop_front();
      checks++;
      if (ob !== e.f) begin
        errors++;
        $display("FAIL shift[%0d] res/cvzi got %h need %h", i, ob, e.f);
      end
      checks++;
      if (lat != e.lat) begin
        errors++;
        $display("FAIL shift_lat[%0d] got %0d need %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_mul;
    logic [15:0] x, y; exp_t e; flags_t ob; int lat;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin x = 16'h0100; y = 16'h0100; e = mk(16'h0000, 0, 1, 1, 0, 17); end
        1: begin x = 16'd300;  y = 16'd200;  e = mk(16'hEA60, 0, 0, 0, 0, 17); end
        default: begin x = 16'hFFFF; y = 16'hFFFF; e = mk(16'h0001, 0, 1, 0, 0, 17); end
      endcase
      exp_q.push_back(e);
      run_op(MUL, x, y, 8'h00, ob, lat);
      e = exp_q.pop_front();
      checks++;
      if (ob !== e.f) begin
        errors++;
        $display("FAIL mul[%0d] res/cvzi got %h need %h", i, ob, e.f);
      end
      checks++;
      if (lat != e.lat) begin
        errors++;
        $display("FAIL mul_lat[%0d] got %0d need %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] o; logic [15:0] x, y; logic [7:0] im; exp_t e; flags_t ob; int lat;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom); x = 16'($urandom); y = 16'($urandom); im = 8'($urandom);
      exp_q.push_back(model(o, x, y, im));
      run_op(o, x, y, im, ob, lat);
      e = exp_q.pop_front();
      checks++;
      if (ob !== e.f || lat != e.lat) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h imm=%h got %h lat %0d need %h lat %0d",
                 i, o, x, y, im, ob, lat, e.f, e.lat);
      end
    end
  endtask

  task automatic test_backpressure;
    int w; bit bad; flags_t ob; flags_t need;
    need = '{res: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, ill: 1'b0};
    op = ADD; a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ob = '{res: result, c: carry, v: ovf, z: zero, ill: illegal};
      if (ob !== need || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
      // A new request while DONE must be ignored.
      if (c == 1) begin op = SUB; a = 16'h0009; b = 16'h0002; in_valid = 1'b1; end
      if (c == 3) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold res/cvzi got %h need %h rdy=%b vld=%b", ob, need, in_ready, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release vld/rdy got %b/%b need 0/1", out_valid, in_ready);
    end
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_ignored_op out_valid got 1 need 0");
    end
  endtask

  task automatic test_reset_mid_mul;
    bit bad;
    op = MUL; a = 16'd300; b = 16'd200; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2; rst = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid vld/rdy/res got %b/%b/%h need 0/1/0000", out_valid, in_ready, result);
    end
    @(posedge clk); #1; rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_abort out_valid got 1 need 0");
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_arith();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 16-bit SUB/SLL/ADDI/AND datapath units.
- One registered execution unit with a valid/ready handshake on both sides.
- Single-cycle ops: ADD, SUB, AND, ADDI.
- Iterative ops: SLL/SRL at one bit per cycle; MUL by shift-add, one bit per cycle.
- Sits between decode/register-read and writeback; the CPU stalls on in_ready.

Parameters:
- W, 16: datapath width (≥ 4).
- IMM_W, 8: immediate width for ADDI; sign-extended to W (IMM_W ≤ W).
- SH_W, $clog2(W)+1: shift-amount field width, taken from b[SH_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 ADDI, 100 SLL, 101 SRL, 110 MUL, 111 reserved.
- a  in  W  operand A.
- b  in  W  operand B; low SH_W bits are the shift amount for SLL/SRL.
- imm  in  IMM_W  ADDI immediate.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  W  registered result.
- carry  out  1  ADD/ADDI carry-out; SUB borrow (a < b unsigned); 0 otherwise.
- ovf  out  1  signed overflow for ADD/SUB/ADDI; for MUL, 1 if the unsigned upper W bits of the product are nonzero; 0 otherwise.
- zero  out  1  result == 0.
- illegal  out  1  op was 111.

Behaviour:
- Reset (async, any state): state=IDLE; result, carry, ovf, zero, illegal=0; out_valid=0; in_ready=1; internal counter and accumulators cleared.
- Reset mid-operation aborts the op; no result is produced.
- States: IDLE, BUSY, DONE.
- Accept: in_valid && in_ready at a rising edge. Operands, op and imm are latched; later input changes are ignored.
- Single-cycle ops (ADD, SUB, AND, ADDI, reserved): IDLE→DONE.
  - out_valid is high the cycle after accept (latency 1).
- SLL/SRL:
  - k = b[SH_W-1:0], clamped to W.
  - k=0: IDLE→DONE, result=a, latency 1.
  - Otherwise: IDLE→BUSY, shift 1 bit per cycle for k cycles, then DONE; latency k+1.
  - Any k ≥ W yields result 0 after W+1 cycles.
  - SRL is logical (zero fill).
- MUL:
  - Unsigned shift-add over 2W-bit product.
  - IDLE→BUSY for exactly W cycles, then DONE; latency W+1.
  - result = low W bits.
- Arithmetic:
  - All sums are modulo 2^W.
  - ADDI: result = a + sign-extended imm. carry/ovf are computed as for ADD with the extended operand.
  - SUB: result = a + ~b + 1. carry = borrow.
- Reserved op: result=0, illegal=1, zero=1, carry=0, ovf=0. Otherwise illegal=0.
- DONE:
  - out_valid=1; result and flags are stable until the handshake.
  - out_valid && out_ready → IDLE; out_valid falls the next cycle.
  - in_ready rises in that same next cycle. No accept in the cycle DONE exits, so peak throughput is one op per 2 cycles for single-cycle ops.
- Flag updates: result and flags update only on entry to DONE. BUSY keeps the previous result visible with out_valid=0.
- out_ready while not DONE is ignored.
- in_valid while BUSY/DONE is ignored; the requester must hold in_valid until in_ready.

Test Plan:
- Reset then ADD, W=16: a=16'hFFFF, b=16'h0001 → after 1 cycle, result=0, carry=1, zero=1, ovf=0. Then ADD a=16'h7FFF, b=1 → result 16'h8000, ovf=1, carry=0.
- SUB a=3, b=5 → result 16'hFFFE, carry(borrow)=1, ovf=0. ADDI a=16'h0010, imm=8'hF0 → result 16'h0000, carry=1, zero=1.
- SLL a=16'h0001, b=4 → out_valid exactly 5 cycles after accept, result 16'h0010. SRL a=16'h8000, b=15 → 16'h0001 after 16 cycles. SLL b=20 → result 0 after 17 cycles. SLL b=0 → result a after 1 cycle.
- MUL a=16'h0100, b=16'h0100 → out_valid after 17 cycles, result 0, ovf=1. MUL a=300, b=200 → result 16'hEA60, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result/flags stable, in_ready=0. Pulse in_valid with a new op meanwhile → op ignored. Raise out_ready → IDLE next cycle.
- Assert rst mid-MUL (cycle 8) → out_valid=0 and in_ready=1 immediately (async). A new AND a=16'hF0F0, b=16'h0FF0 → result 16'h00F0. Op 111 → illegal=1, result=0.
